// File: rtl/vector_pkg.sv
// Shared definitions for the vector display-list sequencer: entry layout,
// command codes and controller state encodings.
package vector_pkg;

  localparam int ENTRY_W = 18;
  localparam int CMD_LSB = 16;
  localparam int X_LSB   = 8;
  localparam int Y_LSB   = 0;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'd0,
    CMD_MOVE = 2'd1,
    CMD_DRAW = 2'd2,
    CMD_END  = 2'd3
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_LAUNCH    = 3'd3,
    S_WAIT_BUSY = 3'd4,
    S_DRAWING   = 3'd5,
    S_FRAME_END = 3'd6
  } state_t;

endpackage

// File: rtl/vector_list_sequencer.sv
// Walks a display list of MOVE/DRAW/NOP/END entries, tracks the pen and
// launches one line-engine run per DRAW, holding its endpoints for the line.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | waiting for start
// S_FETCH     | read strobe for entry at addr (or halt if stop pending)
// S_DECODE    | entry data valid; execute command
// S_LAUNCH    | pulse ld_go once the engine is idle
// S_WAIT_BUSY | wait for the engine to report busy
// S_DRAWING   | wait for the engine to finish the line
// S_FRAME_END | frame_done pulse; loop or return to idle
module vector_list_sequencer
  import vector_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              loop_en_i,
  input  logic              stop_i,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              err_o,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [17:0]       mem_data_i,
  output logic              ld_go_o,
  input  logic              ld_busy_i,
  output logic [7:0]        ld_stax_o,
  output logic [7:0]        ld_stay_o,
  output logic [7:0]        ld_endx_o,
  output logic [7:0]        ld_endy_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          pen_x_q, pen_y_q;
  logic [7:0]          sta_x_q, sta_y_q, end_x_q, end_y_q;
  logic [CNT_W-1:0]    tmo_q;
  logic                stop_q, last_q, err_q, busy_q, done_q, rd_q;

  cmd_t       cmd;
  logic [7:0] ent_x, ent_y;
  logic       line_active, tmo_hit, halt_next, at_last;

  assign cmd         = cmd_t'(mem_data_i[CMD_LSB +: 2]);
  assign ent_x       = mem_data_i[X_LSB +: 8];
  assign ent_y       = mem_data_i[Y_LSB +: 8];
  assign line_active = (state_q inside {S_LAUNCH, S_WAIT_BUSY, S_DRAWING});
  assign tmo_hit     = (tmo_q == '0);
  assign at_last     = (addr_q == '1);
  // Stop flag as it will be seen in the next cycle; gates the read strobe of a coming FETCH.
  assign halt_next   = stop_q | stop_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      pen_x_q <= '0;
      pen_y_q <= '0;
      sta_x_q <= '0;
      sta_y_q <= '0;
      end_x_q <= '0;
      end_y_q <= '0;
      tmo_q   <= '0;
      stop_q  <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      rd_q   <= 1'b0;
      if (stop_i && state_q != S_IDLE) stop_q <= 1'b1;
      if (line_active) tmo_q <= tmo_q - CNT_W'(1);

      if (line_active && tmo_hit) begin
        state_q <= S_IDLE;
        err_q   <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i) begin
              state_q <= S_FETCH;
              addr_q  <= '0;
              pen_x_q <= '0;
              pen_y_q <= '0;
              err_q   <= 1'b0;
              stop_q  <= 1'b0;
              last_q  <= 1'b0;
              busy_q  <= 1'b1;
              rd_q    <= 1'b1;
            end
          end
          S_FETCH: begin
            if (stop_q) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_DECODE;
            end
          end
          S_DECODE: begin
            if (cmd == CMD_MOVE || cmd == CMD_DRAW) begin
              pen_x_q <= ent_x;
              pen_y_q <= ent_y;
            end
            if (cmd == CMD_DRAW) begin
              sta_x_q <= pen_x_q;
              sta_y_q <= pen_y_q;
              end_x_q <= ent_x;
              end_y_q <= ent_y;
            end
            if (cmd == CMD_END) begin
              state_q <= S_FRAME_END;
              done_q  <= 1'b1;
            end else begin
              // The last entry never wraps; it forces an END after executing.
              if (at_last) begin
                err_q  <= 1'b1;
                last_q <= 1'b1;
              end else begin
                addr_q <= addr_q + ADDR_W'(1);
              end
              if (cmd == CMD_DRAW) begin
                state_q <= S_LAUNCH;
                tmo_q   <= CNT_W'(TIMEOUT);
              end else if (at_last) begin
                state_q <= S_FRAME_END;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_FETCH;
                rd_q    <= ~halt_next;
              end
            end
          end
          S_LAUNCH: begin
            if (!ld_busy_i) state_q <= S_WAIT_BUSY;
          end
          S_WAIT_BUSY: begin
            if (ld_busy_i) state_q <= S_DRAWING;
          end
          S_DRAWING: begin
            if (!ld_busy_i) begin
              if (last_q) begin
                state_q <= S_FRAME_END;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_FETCH;
                rd_q    <= ~halt_next;
              end
            end
          end
          S_FRAME_END: begin
            last_q <= 1'b0;
            if (loop_en_i && !stop_q) begin
              addr_q  <= '0;
              state_q <= S_FETCH;
              rd_q    <= ~halt_next;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign err_o        = err_q;
  assign mem_rd_o     = rd_q;
  assign mem_addr_o   = addr_q;
  assign ld_go_o      = (state_q == S_LAUNCH) & ~ld_busy_i & ~tmo_hit;
  assign ld_stax_o    = sta_x_q;
  assign ld_stay_o    = sta_y_q;
  assign ld_endx_o    = end_x_q;
  assign ld_endy_o    = end_y_q;

endmodule

// File: tb/tb_vector_list_sequencer.sv
// Bench for vector_list_sequencer: memory and line-engine models around the
// DUT, with expected lines and frame timing computed from the list contents.
module tb_vector_list_sequencer;

  localparam int AW  = 6;
  localparam int TMO = 15;
  localparam logic [1:0] C_NOP = 2'd0, C_MOVE = 2'd1, C_DRAW = 2'd2, C_END = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, loop_en, stop;
  logic          busy, frame_done, err, mem_rd, ld_go, ld_busy;
  logic [AW-1:0] mem_addr;
  logic [17:0]   mem_data;
  logic [7:0]    ld_stax, ld_stay, ld_endx, ld_endy;
  logic [31:0]   ld_eps;
  assign ld_eps = {ld_stax, ld_stay, ld_endx, ld_endy};

  logic          s_start, s_busy, s_done, s_err, s_rd, s_go;
  logic [1:0]    s_addr;
  logic [7:0]    s_sx, s_sy, s_ex, s_ey;
  logic [17:0]   s_data;
  logic          s_zero;
  assign s_data = 18'd0;
  assign s_zero = 1'b0;

  vector_list_sequencer #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .loop_en_i(loop_en), .stop_i(stop),
    .busy_o(busy), .frame_done_o(frame_done), .err_o(err), .mem_rd_o(mem_rd),
    .mem_addr_o(mem_addr), .mem_data_i(mem_data), .ld_go_o(ld_go), .ld_busy_i(ld_busy),
    .ld_stax_o(ld_stax), .ld_stay_o(ld_stay), .ld_endx_o(ld_endx), .ld_endy_o(ld_endy)
  );

  vector_list_sequencer #(.ADDR_W(2), .TIMEOUT(TMO)) dut_small (
    .clk_i(clk), .rst_i(rst), .start_i(s_start), .loop_en_i(s_zero), .stop_i(s_zero),
    .busy_o(s_busy), .frame_done_o(s_done), .err_o(s_err), .mem_rd_o(s_rd),
    .mem_addr_o(s_addr), .mem_data_i(s_data), .ld_go_o(s_go), .ld_busy_i(s_zero),
    .ld_stax_o(s_sx), .ld_stay_o(s_sy), .ld_endx_o(s_ex), .ld_endy_o(s_ey)
  );

  // display-list memory, one cycle read latency
  logic [17:0] mem [64];
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  // line engine: busy for a programmable number of cycles after ld_go
  int   eng_len = 3;
  int   eng_lens[$];
  int   eng_cnt = 0;
  logic eng_dead = 1'b0;
  always @(posedge clk) begin
    if (ld_go && !eng_dead) begin
      if (eng_lens.size() > 0) eng_cnt <= eng_lens.pop_front();
      else eng_cnt <= eng_len;
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
    end
  end
  assign ld_busy = (eng_cnt > 0);

  // monitors
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] got_lines[$];
  int busy_cnt, done_cnt, done_cyc, loop_rd_cnt, go_cnt, go_cyc, first_go_cyc;
  int idle_cyc, stab_err, go_bad;
  logic busy_prev, trk;
  logic [31:0] trk_val;
  int s_rd_cnt, s_done_cnt, s_order_err;
  logic s_err_at_done;

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (busy_prev && !busy) idle_cyc = cyc;
    busy_prev = busy;
    if (frame_done) begin done_cnt++; done_cyc = cyc; end
    if (mem_rd && cyc == done_cyc + 1 && mem_addr == '0) loop_rd_cnt++;
    if (ld_go && ld_busy) go_bad++;
    if (ld_go) begin
      if (go_cnt == 0) first_go_cyc = cyc;
      go_cnt++;
      go_cyc = cyc;
      got_lines.push_back(ld_eps);
      trk = 1'b1;
      trk_val = ld_eps;
    end else if (trk) begin
      if (ld_eps !== trk_val) stab_err++;
      if (!ld_busy && cyc > go_cyc + 1) trk = 1'b0;
    end
    if (s_rd) begin
      if (int'(s_addr) != s_rd_cnt) s_order_err++;
      s_rd_cnt++;
    end
    if (s_done) begin s_done_cnt++; s_err_at_done = s_err; end
  end

  int n_checks = 0;
  int n_fail = 0;

  logic [1:0]  l_cmd [64];
  logic [7:0]  l_x [64];
  logic [7:0]  l_y [64];
  logic [31:0] exp_lines[$];
  int          exp_busy;
  int          start_cyc;

  task automatic new_list();
    for (int i = 0; i < 64; i++) begin l_cmd[i] = C_NOP; l_x[i] = 0; l_y[i] = 0; end
  endtask

  task automatic put(input int i, input logic [1:0] c, input logic [7:0] x, input logic [7:0] y);
    l_cmd[i] = c; l_x[i] = x; l_y[i] = y;
  endtask

  task automatic load_list();
    for (int i = 0; i < 64; i++) mem[i] = {l_cmd[i], l_x[i], l_y[i]};
  endtask

  // Reference: walk the list frame by frame, pen carried across frames.
  function automatic void model(input int frames);
    logic [7:0] px, py;
    int lens[$];
    bit fin;
    int n;
    lens = eng_lens;
    exp_lines.delete();
    exp_busy = 0;
    px = 0; py = 0;
    for (int f = 0; f < frames; f++) begin
      fin = 0;
      for (int i = 0; i < 64 && !fin; i++) begin
        case (l_cmd[i])
          C_NOP: exp_busy += 2;
          C_MOVE: begin px = l_x[i]; py = l_y[i]; exp_busy += 2; end
          C_DRAW: begin
            exp_lines.push_back({px, py, l_x[i], l_y[i]});
            px = l_x[i]; py = l_y[i];
            if (lens.size() > 0) n = lens.pop_front(); else n = eng_len;
            exp_busy += 4 + n;
          end
          default: begin exp_busy += 3; fin = 1; end
        endcase
      end
    end
  endfunction

  task automatic clear_mon();
    @(posedge clk); #1;
    got_lines.delete();
    busy_cnt = 0; done_cnt = 0; done_cyc = -10; loop_rd_cnt = 0; go_cnt = 0;
    go_cyc = -10; first_go_cyc = -10; idle_cyc = -10; stab_err = 0; go_bad = 0; trk = 1'b0;
  endtask

  task automatic kick();
    @(negedge clk); start = 1'b1; start_cyc = cyc;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k;
    k = 0;
    while (busy && k < budget) begin @(negedge clk); k++; end
    n_checks++;
    if (busy) begin n_fail++; $display("FAIL %s_wait: busy still 1 after %0d cycles", nm, budget); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", frame_done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", err); end
    n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL rst_rd: got %b expected 0", mem_rd); end
    n_checks++; if (mem_addr !== '0) begin n_fail++; $display("FAIL rst_addr: got %0d expected 0", mem_addr); end
    n_checks++; if (ld_go !== 1'b0) begin n_fail++; $display("FAIL rst_go: got %b expected 0", ld_go); end
    n_checks++; if (ld_eps !== 32'd0) begin n_fail++; $display("FAIL rst_eps: got %h expected 0", ld_eps); end
    n_checks++; if (s_busy !== 1'b0 || s_err !== 1'b0) begin n_fail++; $display("FAIL rst_small: got busy %b err %b expected 0 0", s_busy, s_err); end
  endtask

  task automatic test_basic();
    clear_mon();
    new_list(); put(0, C_MOVE, 10, 10); put(1, C_DRAW, 20, 15); put(2, C_END, 0, 0); load_list();
    eng_len = 4; model(1);
    kick(); wait_idle(200, "basic");
    n_checks++; if (got_lines.size() != exp_lines.size()) begin n_fail++; $display("FAIL basic_nlines: got %0d expected %0d", got_lines.size(), exp_lines.size()); end
    for (int i = 0; i < exp_lines.size() && i < got_lines.size(); i++) begin
      n_checks++; if (got_lines[i] !== exp_lines[i]) begin n_fail++; $display("FAIL basic_line%0d: got %h expected %h", i, got_lines[i], exp_lines[i]); end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_frames: got %0d expected 1", done_cnt); end
    n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL basic_stable: got %0d changes expected 0", stab_err); end
    n_checks++; if (busy_cnt != exp_busy) begin n_fail++; $display("FAIL basic_cycles: got %0d expected %0d", busy_cnt, exp_busy); end
  endtask

  task automatic test_degenerate();
    clear_mon();
    new_list(); put(0, C_DRAW, 5, 5); put(1, C_DRAW, 5, 5); put(2, C_END, 0, 0); load_list();
    eng_lens = {3, 1}; model(1);
    kick(); wait_idle(200, "degen");
    n_checks++; if (got_lines.size() != 2) begin n_fail++; $display("FAIL degen_nlines: got %0d expected 2", got_lines.size()); end
    for (int i = 0; i < exp_lines.size() && i < got_lines.size(); i++) begin
      n_checks++; if (got_lines[i] !== exp_lines[i]) begin n_fail++; $display("FAIL degen_line%0d: got %h expected %h", i, got_lines[i], exp_lines[i]); end
    end
    n_checks++; if (first_go_cyc - start_cyc != 3) begin n_fail++; $display("FAIL degen_go_latency: got %0d expected 3", first_go_cyc - start_cyc); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL degen_frames: got %0d expected 1", done_cnt); end
    n_checks++; if (busy_cnt != exp_busy) begin n_fail++; $display("FAIL degen_cycles: got %0d expected %0d", busy_cnt, exp_busy); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL degen_err_cleared: got %b expected 0", err); end
  endtask

  task automatic test_loop();
    int k;
    clear_mon();
    new_list(); put(0, C_DRAW, 40, 7); put(1, C_DRAW, 90, 200); put(2, C_END, 0, 0); load_list();
    eng_len = 2; model(3);
    loop_en = 1'b1;
    kick();
    k = 0;
    while (done_cnt < 2 && k < 300) begin @(posedge clk); #2; k++; end
    loop_en = 1'b0;
    wait_idle(200, "loop");
    n_checks++; if (done_cnt != 3) begin n_fail++; $display("FAIL loop_frames: got %0d expected 3", done_cnt); end
    n_checks++; if (got_lines.size() != exp_lines.size()) begin n_fail++; $display("FAIL loop_nlines: got %0d expected %0d", got_lines.size(), exp_lines.size()); end
    for (int i = 0; i < exp_lines.size() && i < got_lines.size(); i++) begin
      n_checks++; if (got_lines[i] !== exp_lines[i]) begin n_fail++; $display("FAIL loop_line%0d: got %h expected %h", i, got_lines[i], exp_lines[i]); end
    end
    n_checks++; if (loop_rd_cnt != 2) begin n_fail++; $display("FAIL loop_refetch: got %0d expected 2", loop_rd_cnt); end
    n_checks++; if (busy_cnt != exp_busy) begin n_fail++; $display("FAIL loop_cycles: got %0d expected %0d", busy_cnt, exp_busy); end
  endtask

  task automatic test_timeout();
    clear_mon();
    new_list(); put(0, C_DRAW, 1, 2); put(1, C_END, 0, 0); load_list();
    eng_dead = 1'b1;
    kick(); wait_idle(100, "tmo");
    eng_dead = 1'b0;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b expected 1", err); end
    n_checks++; if (idle_cyc - go_cyc != TMO + 1) begin n_fail++; $display("FAIL tmo_latency: got %0d expected %0d", idle_cyc - go_cyc, TMO + 1); end
    n_checks++; if (go_cnt != 1 || done_cnt != 0) begin n_fail++; $display("FAIL tmo_events: got go %0d done %0d expected 1 0", go_cnt, done_cnt); end
    repeat (5) @(negedge clk);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b expected 1", err); end
  endtask

  task automatic test_stop();
    int k;
    clear_mon();
    new_list(); put(0, C_DRAW, 10, 20); put(1, C_DRAW, 30, 40); put(2, C_DRAW, 50, 60); put(3, C_END, 0, 0); load_list();
    eng_len = 6;
    kick();
    k = 0;
    while (!(go_cnt == 1 && ld_busy) && k < 50) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    wait_idle(100, "stop");
    n_checks++; if (go_cnt != 1) begin n_fail++; $display("FAIL stop_lines: got %0d expected 1", go_cnt); end
    n_checks++; if (got_lines.size() < 1 || got_lines[0] !== 32'h00000A14) begin n_fail++; $display("FAIL stop_first_line: got %0d lines, expected 00000a14", got_lines.size()); end
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL stop_frames: got %0d expected 0", done_cnt); end
    n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL stop_stable: got %0d changes expected 0", stab_err); end
    // stop alone in idle, then stop together with start: the frame must still run
    clear_mon();
    eng_len = 2; model(1);
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    @(negedge clk); stop = 1'b1; start = 1'b1;
    @(negedge clk); stop = 1'b0; start = 1'b0;
    wait_idle(200, "stopstart");
    n_checks++; if (done_cnt != 1 || go_cnt != 3) begin n_fail++; $display("FAIL stopstart_run: got done %0d go %0d expected 1 3", done_cnt, go_cnt); end
  endtask

  task automatic test_midline_reset();
    int k;
    clear_mon();
    new_list(); put(0, C_DRAW, 3, 4); put(1, C_END, 0, 0); load_list();
    eng_len = 10;
    kick();
    k = 0;
    while (go_cnt == 0 && k < 20) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    clear_mon();
    new_list(); put(0, C_DRAW, 7, 9); put(1, C_END, 0, 0); load_list();
    eng_len = 2;
    kick(); wait_idle(100, "midrst");
    n_checks++; if (go_bad != 0) begin n_fail++; $display("FAIL midrst_go_while_busy: got %0d expected 0", go_bad); end
    n_checks++; if (got_lines.size() != 1 || got_lines[0] !== 32'h00000709) begin n_fail++; $display("FAIL midrst_line: got %0d lines, expected 00000709", got_lines.size()); end
    n_checks++; if (first_go_cyc - start_cyc <= 3) begin n_fail++; $display("FAIL midrst_stall: go after %0d cycles expected more than 3", first_go_cyc - start_cyc); end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 5; it++) begin
      clear_mon();
      new_list();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++)
        put(i, 2'($urandom_range(0, 2)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      put(n, C_END, 0, 0);
      load_list();
      eng_len = $urandom_range(1, 8);
      model(1);
      kick(); wait_idle(400, "rand");
      n_checks++; if (got_lines.size() != exp_lines.size()) begin n_fail++; $display("FAIL rand%0d_nlines: got %0d expected %0d", it, got_lines.size(), exp_lines.size()); end
      for (int i = 0; i < exp_lines.size() && i < got_lines.size(); i++) begin
        n_checks++; if (got_lines[i] !== exp_lines[i]) begin n_fail++; $display("FAIL rand%0d_line%0d: got %h expected %h", it, i, got_lines[i], exp_lines[i]); end
      end
      n_checks++; if (done_cnt != 1 || err !== 1'b0) begin n_fail++; $display("FAIL rand%0d_frame: got done %0d err %b expected 1 0", it, done_cnt, err); end
      n_checks++; if (busy_cnt != exp_busy) begin n_fail++; $display("FAIL rand%0d_cycles: got %0d expected %0d", it, busy_cnt, exp_busy); end
      n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL rand%0d_stable: got %0d changes expected 0", it, stab_err); end
    end
  endtask

  task automatic test_overflow();
    int k;
    s_rd_cnt = 0; s_done_cnt = 0; s_order_err = 0; s_err_at_done = 1'b0;
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    k = 0;
    while (s_busy && k < 100) begin @(negedge clk); k++; end
    @(negedge clk);
    n_checks++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL ovf_idle: got busy %b expected 0", s_busy); end
    n_checks++; if (s_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b expected 1", s_err); end
    n_checks++; if (s_done_cnt != 1 || s_err_at_done !== 1'b1) begin n_fail++; $display("FAIL ovf_done: got %0d err_at_done %b expected 1 1", s_done_cnt, s_err_at_done); end
    n_checks++; if (s_rd_cnt != 4 || s_order_err != 0) begin n_fail++; $display("FAIL ovf_reads: got %0d reads %0d out of order expected 4 0", s_rd_cnt, s_order_err); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; loop_en = 1'b0; stop = 1'b0; s_start = 1'b0;
    busy_prev = 1'b0; trk = 1'b0; done_cyc = -10;
    s_rd_cnt = 0; s_done_cnt = 0; s_order_err = 0; s_err_at_done = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_timeout();
    test_degenerate();
    test_loop();
    test_stop();
    test_midline_reset();
    test_random();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
